// File: rtl/alu_issue.sv
// alu_issue: sequential initiator for the shared combinational ALU in the
// execute stage. Takes one decoded RV32I integer/branch micro-op from IDU,
// drives the external ALU for one pass (integer ops) or two passes
// (branches: compare, then target add), and presents the registered
// result to WBU over a valid/ready handshake.
module alu_issue #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  // IDU side
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [XLEN-1:0] in_rs1_i,
  input  logic [XLEN-1:0] in_rs2_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic [2:0]      in_funct3_i,
  input  logic            in_funct7b5_i,
  input  logic [2:0]      in_kind_i,
  input  logic [RD_W-1:0] in_rd_i,
  // shared ALU
  output logic [XLEN-1:0] alu_r1_o,
  output logic [XLEN-1:0] alu_r2_o,
  output logic [3:0]      alu_sub_o,
  output logic            alu_enable_o,
  input  logic [XLEN-1:0] alu_sum_i,
  input  logic            alu_overflow_i,
  // WBU side
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  output logic [RD_W-1:0] out_rd_o,
  output logic            out_wen_o,
  output logic            out_br_taken_o,
  output logic [XLEN-1:0] out_br_target_o
);

  // ALU operation codes understood by the shared ALU.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_EQ   = 4'b1011;

  // Micro-op kinds; encodings 5-7 are illegal.
  localparam logic [2:0] KIND_OP     = 3'd0;
  localparam logic [2:0] KIND_OPIMM  = 3'd1;
  localparam logic [2:0] KIND_BRANCH = 3'd2;
  localparam logic [2:0] KIND_LUI    = 3'd3;
  localparam logic [2:0] KIND_AUIPC  = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    BR_TGT = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [2:0]      kind;
    logic [RD_W-1:0] rd;
  } uop_t;

  state_t          state_q, state_d;
  uop_t            op_q;
  logic [XLEN-1:0] out_result_q;
  logic [RD_W-1:0] out_rd_q;
  logic            out_wen_q;
  logic            br_taken_q;
  logic [XLEN-1:0] br_target_q;

  // Decode of the latched micro-op for the EXEC pass.
  logic            kind_legal;
  logic            is_branch;
  logic            branch_legal;
  logic [XLEN-1:0] exec_r1;
  logic [XLEN-1:0] exec_r2;
  logic [3:0]      exec_op;

  // Debug-only ALU flag; intentionally not consumed by the datapath.
  logic unused_ok;
  assign unused_ok = alu_overflow_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    else     state_q <= state_d;
  end

  // Operand and opcode selection for the EXEC pass.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    kind_legal   = 1'b1;
    is_branch    = 1'b0;
    branch_legal = 1'b0;
    exec_r1      = '0;
    exec_r2      = '0;
    exec_op      = ALU_ADD;
    unique case (op_q.kind)
      KIND_OP, KIND_OPIMM: begin
        exec_r1 = op_q.rs1;
        exec_r2 = (op_q.kind == KIND_OP) ? op_q.rs2 : op_q.imm;
        unique case (op_q.funct3)
          3'b000: exec_op = (op_q.kind == KIND_OP && op_q.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: exec_op = ALU_SLL;
          3'b010: exec_op = ALU_SLT;
          3'b011: exec_op = ALU_SLTU;
          3'b100: exec_op = ALU_XOR;
          3'b101: exec_op = op_q.funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: exec_op = ALU_OR;
          default: exec_op = ALU_AND;
        endcase
      end
      KIND_BRANCH: begin
        is_branch = 1'b1;
        unique case (op_q.funct3)
          3'b000, 3'b001: begin branch_legal = 1'b1; exec_op = ALU_EQ;   end
          3'b100, 3'b101: begin branch_legal = 1'b1; exec_op = ALU_SLT;  end
          3'b110, 3'b111: begin branch_legal = 1'b1; exec_op = ALU_SLTU; end
          default:        branch_legal = 1'b0;
        endcase
        // An illegal branch leaves the ALU idle.
        if (branch_legal) begin
          exec_r1 = op_q.rs1;
          exec_r2 = op_q.rs2;
        end else begin
          exec_op = ALU_ADD;
        end
      end
      KIND_LUI: begin
        exec_r1 = '0;
        exec_r2 = op_q.imm;
      end
      KIND_AUIPC: begin
        exec_r1 = op_q.pc;
        exec_r2 = op_q.imm;
      end
      default: kind_legal = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i) state_d = EXEC;
      EXEC:    state_d = (is_branch && branch_legal) ? BR_TGT : DONE;
      BR_TGT:  state_d = DONE;
      default: if (out_ready_i) state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: handshakes and ALU drive.
  always_comb begin
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    alu_enable_o = 1'b0;
    alu_r1_o     = '0;
    alu_r2_o     = '0;
    alu_sub_o    = ALU_ADD;
    unique case (state_q)
      IDLE: in_ready_o = 1'b1;
      EXEC: begin
        if (kind_legal && (!is_branch || branch_legal)) begin
          alu_enable_o = 1'b1;
          alu_r1_o     = exec_r1;
          alu_r2_o     = exec_r2;
          alu_sub_o    = exec_op;
        end
      end
      BR_TGT: begin
        alu_enable_o = 1'b1;
        alu_r1_o     = op_q.pc;
        alu_r2_o     = op_q.imm;
        alu_sub_o    = ALU_ADD;
      end
      default: out_valid_o = 1'b1;
    endcase
  end

  // Micro-op latch and registered result/branch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_wen_q    <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            op_q.pc       <= in_pc_i;
            op_q.rs1      <= in_rs1_i;
            op_q.rs2      <= in_rs2_i;
            op_q.imm      <= in_imm_i;
            op_q.funct3   <= in_funct3_i;
            op_q.funct7b5 <= in_funct7b5_i;
            op_q.kind     <= in_kind_i;
            op_q.rd       <= in_rd_i;
          end
        end
        EXEC: begin
          out_rd_q    <= op_q.rd;
          br_target_q <= '0;
          if (!kind_legal) begin
            out_result_q <= '0;
            out_wen_q    <= 1'b0;
            br_taken_q   <= 1'b0;
          end else if (is_branch) begin
            out_result_q <= '0;
            out_wen_q    <= 1'b0;
            // Odd funct3 (BNE/BGE/BGEU) is the inverse of the compare.
            br_taken_q   <= branch_legal && (alu_sum_i[0] ^ op_q.funct3[0]);
          end else begin
            out_result_q <= alu_sum_i;
            out_wen_q    <= (op_q.rd != '0);
            br_taken_q   <= 1'b0;
          end
        end
        BR_TGT: br_target_q <= br_taken_q ? alu_sum_i : '0;
        default: ;
      endcase
    end
  end

  assign out_result_o    = out_result_q;
  assign out_rd_o        = out_rd_q;
  assign out_wen_o       = out_wen_q;
  assign out_br_taken_o  = br_taken_q;
  assign out_br_target_o = br_target_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue. A behavioural
// model of the shared ALU answers the DUT's operand requests; all expected
// outputs are hand-computed constants.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [2:0]  in_funct3, in_kind;
  logic        in_funct7b5;
  logic [4:0]  in_rd;
  logic [31:0] alu_r1, alu_r2, alu_sum;
  logic [3:0]  alu_sub;
  logic        alu_enable, alu_overflow;
  logic        out_valid, out_ready, out_wen, out_br_taken;
  logic [31:0] out_result, out_br_target;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pc_i(in_pc), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_imm_i(in_imm),
    .in_funct3_i(in_funct3), .in_funct7b5_i(in_funct7b5),
    .in_kind_i(in_kind), .in_rd_i(in_rd),
    .alu_r1_o(alu_r1), .alu_r2_o(alu_r2), .alu_sub_o(alu_sub),
    .alu_enable_o(alu_enable), .alu_sum_i(alu_sum),
    .alu_overflow_i(alu_overflow),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_rd_o(out_rd), .out_wen_o(out_wen),
    .out_br_taken_o(out_br_taken), .out_br_target_o(out_br_target)
  );

  // Behavioural shared ALU.
  always_comb begin
    alu_overflow = 1'b0;
    case (alu_sub)
      4'b0000: alu_sum = alu_r1 + alu_r2;
      4'b0001: alu_sum = alu_r1 - alu_r2;
      4'b0011: alu_sum = alu_r1 & alu_r2;
      4'b0100: alu_sum = alu_r1 | alu_r2;
      4'b0101: alu_sum = alu_r1 ^ alu_r2;
      4'b0110: alu_sum = {31'd0, $signed(alu_r1) < $signed(alu_r2)};
      4'b0111: alu_sum = {31'd0, alu_r1 < alu_r2};
      4'b1000: alu_sum = alu_r1 << alu_r2[4:0];
      4'b1001: alu_sum = alu_r1 >> alu_r2[4:0];
      4'b1010: alu_sum = $unsigned($signed(alu_r1) >>> alu_r2[4:0]);
      4'b1011: alu_sum = {31'd0, alu_r1 == alu_r2};
      default: alu_sum = 32'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one micro-op for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] kind, input logic [2:0] f3,
                       input logic f7, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_kind = kind; in_funct3 = f3; in_funct7b5 = f7; in_pc = pc;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, alu_enable} !== 3'b100) begin
      errors++; $display("FAIL reset_hs: ready/valid/en=%b want 100", {in_ready, out_valid, alu_enable});
    end
    // Taken BEQ into DONE, then reset while out_valid is high.
    out_ready = 1'b0;
    issue(3'd2, 3'b000, 1'b0, 32'h100, 32'd4, 32'd4, 32'h20, 5'd6);
    tick(); tick();
    checks++;
    if ({out_valid, out_br_taken, out_br_target} !== {2'b11, 32'h120}) begin
      errors++; $display("FAIL pre_reset_beq: valid/taken=%b target=%h want 11 00000120", {out_valid, out_br_taken}, out_br_target);
    end
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, alu_enable} !== 3'b100) begin
      errors++; $display("FAIL mid_done_reset_hs: ready/valid/en=%b want 100", {in_ready, out_valid, alu_enable});
    end
    checks++;
    if ({out_result, out_rd, out_wen, out_br_taken, out_br_target, alu_r1, alu_r2, alu_sub} !== '0) begin
      errors++; $display("FAIL mid_done_reset_vals: result=%h rd=%0d wen=%b taken=%b target=%h r1=%h r2=%h sub=%b want all 0",
                         out_result, out_rd, out_wen, out_br_taken, out_br_target, alu_r1, alu_r2, alu_sub);
    end
    out_ready = 1'b1; tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_handshake: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_op_sub();
    out_ready = 1'b1;
    issue(3'd0, 3'b000, 1'b1, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3);
    checks++;
    if ({alu_enable, alu_sub, out_valid} !== 6'b1_0001_0) begin
      errors++; $display("FAIL sub_exec: en=%b sub=%b valid=%b want 1 0001 0", alu_enable, alu_sub, out_valid);
    end
    tick();
    checks++;
    if ({out_valid, in_ready, out_result, out_wen, out_rd} !== {2'b10, 32'hFFFFFFFE, 1'b1, 5'd3}) begin
      errors++; $display("FAIL sub_done: valid=%b ready=%b result=%h wen=%b rd=%0d want 1 0 fffffffe 1 3",
                         out_valid, in_ready, out_result, out_wen, out_rd);
    end
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL sub_release: valid/ready=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_srai();
    issue(3'd1, 3'b101, 1'b1, 32'h0, 32'h80000000, 32'h0, 32'h404, 5'd5);
    checks++;
    if ({alu_sub, alu_r2} !== {4'b1010, 32'h404}) begin
      errors++; $display("FAIL srai_exec: sub=%b r2=%h want 1010 00000404", alu_sub, alu_r2);
    end
    tick();
    checks++;
    if ({out_valid, out_result, out_wen} !== {1'b1, 32'hF8000000, 1'b1}) begin
      errors++; $display("FAIL srai_done: valid=%b result=%h wen=%b want 1 f8000000 1", out_valid, out_result, out_wen);
    end
    tick();
  endtask

  task automatic test_auipc_wrap();
    issue(3'd4, 3'b000, 1'b0, 32'hFFFFF000, 32'h0, 32'h0, 32'h2000, 5'd8);
    tick();
    checks++;
    if ({out_valid, out_result, out_wen} !== {1'b1, 32'h00001000, 1'b1}) begin
      errors++; $display("FAIL auipc_wrap: valid=%b result=%h wen=%b want 1 00001000 1", out_valid, out_result, out_wen);
    end
    tick();
  endtask

  // Runs a legal branch through compare, target and DONE.
  task automatic run_branch(input string name, input logic [2:0] f3,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [3:0] want_op, input logic want_taken,
                            input logic [31:0] want_target);
    issue(3'd2, f3, 1'b0, 32'h80000010, rs1, rs2, 32'hFFFFFFF8, 5'd0);
    checks++;
    if ({alu_enable, alu_sub} !== {1'b1, want_op}) begin
      errors++; $display("FAIL %s_cmp: en=%b sub=%b want 1 %b", name, alu_enable, alu_sub, want_op);
    end
    tick();
    checks++;
    if ({out_valid, alu_enable, alu_sub, alu_r1, alu_r2} !== {2'b01, 4'b0000, 32'h80000010, 32'hFFFFFFF8}) begin
      errors++; $display("FAIL %s_tgt: valid=%b en=%b sub=%b r1=%h r2=%h want 0 1 0000 80000010 fffffff8",
                         name, out_valid, alu_enable, alu_sub, alu_r1, alu_r2);
    end
    tick();
    checks++;
    if ({out_valid, out_br_taken, out_br_target, out_wen, out_result} !== {1'b1, want_taken, want_target, 1'b0, 32'h0}) begin
      errors++; $display("FAIL %s_done: valid=%b taken=%b target=%h wen=%b result=%h want 1 %b %h 0 00000000",
                         name, out_valid, out_br_taken, out_br_target, out_wen, out_result, want_taken, want_target);
    end
    tick();
  endtask

  task automatic test_branches();
    run_branch("bge_nt", 3'b101, 32'hFFFFFFFF, 32'd1, 4'b0110, 1'b0, 32'h0);
    run_branch("bge_t",  3'b101, 32'd2,        32'd1, 4'b0110, 1'b1, 32'h80000008);
    run_branch("bltu_t", 3'b110, 32'd1, 32'hFFFFFFFF, 4'b0111, 1'b1, 32'h80000008);
    run_branch("bne_nt", 3'b001, 32'd9,        32'd9, 4'b1011, 1'b0, 32'h0);
    // Illegal branch funct3: no target pass, DONE after two cycles.
    issue(3'd2, 3'b010, 1'b0, 32'h80000010, 32'd1, 32'd2, 32'hFFFFFFF8, 5'd0);
    tick();
    checks++;
    if ({out_valid, out_br_taken, out_br_target} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL br_illegal: valid/taken=%b target=%h want 10 00000000", {out_valid, out_br_taken}, out_br_target);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(3'd3, 3'b000, 1'b0, 32'hDEAD0000, 32'h11111111, 32'h0, 32'h12345000, 5'd9);
    checks++;
    if ({alu_r1, alu_r2, alu_sub} !== {32'h0, 32'h12345000, 4'b0000}) begin
      errors++; $display("FAIL lui_exec: r1=%h r2=%h sub=%b want 0 12345000 0000", alu_r1, alu_r2, alu_sub);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_kind = 3'd0; in_funct3 = 3'b000; in_funct7b5 = 1'b0;
        in_rs1 = 32'd1; in_rs2 = 32'd1; in_rd = 5'd2; in_valid = 1'b1;
      end
      checks++;
      if ({out_valid, in_ready, out_result, out_rd} !== {2'b10, 32'h12345000, 5'd9}) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b ready=%b result=%h rd=%0d want 1 0 12345000 9",
                           i, out_valid, in_ready, out_result, out_rd);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release: valid/ready=%b want 01", {out_valid, in_ready});
    end
    tick(); tick();
    checks++;
    if ({out_valid, in_ready, alu_enable} !== 3'b010) begin
      errors++; $display("FAIL bp_idle: valid/ready/en=%b want 010", {out_valid, in_ready, alu_enable});
    end
  endtask

  task automatic test_rd0_and_illegal();
    issue(3'd1, 3'b011, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1, 5'd0);
    checks++;
    if (alu_sub !== 4'b0111) begin
      errors++; $display("FAIL sltiu_exec: sub=%b want 0111", alu_sub);
    end
    tick();
    checks++;
    if ({out_valid, out_result, out_wen} !== {1'b1, 32'd1, 1'b0}) begin
      errors++; $display("FAIL sltiu_rd0: valid=%b result=%h wen=%b want 1 00000001 0", out_valid, out_result, out_wen);
    end
    tick();
    issue(3'd6, 3'b000, 1'b0, 32'h40, 32'd5, 32'd7, 32'h3, 5'd4);
    checks++;
    if (alu_enable !== 1'b0) begin
      errors++; $display("FAIL illegal_exec_en: alu_enable=%b want 0", alu_enable);
    end
    tick();
    checks++;
    if ({out_valid, alu_enable, out_result, out_wen, out_br_taken} !== {2'b10, 32'h0, 2'b00}) begin
      errors++; $display("FAIL illegal_done: valid=%b en=%b result=%h wen=%b taken=%b want 1 0 00000000 0 0",
                         out_valid, alu_enable, out_result, out_wen, out_br_taken);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    in_funct3 = '0; in_funct7b5 = 1'b0; in_kind = '0; in_rd = '0;
    test_reset();
    test_op_sub();
    test_srai();
    test_auipc_wrap();
    test_branches();
    test_backpressure();
    test_rd0_and_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Sequential initiator for the shared combinational ALU in the NPC execute stage. It accepts one decoded RV32I integer or branch micro-op from IDU over a valid/ready handshake. It drives alu r1/r2/sub/alu_enable, registers the ALU result, and hands the result, or the branch decision plus target, to WBU over a second valid/ready handshake. Branches reuse the single ALU for two passes: compare, then target add.

Parameters:
XLEN, 32, datapath width; the ALU interface is fixed at 32.
RD_W, 5, destination register index width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  IDU micro-op valid
in_ready  out  1  block can accept a micro-op
in_pc  in  XLEN  instruction PC
in_rs1  in  XLEN  rs1 value
in_rs2  in  XLEN  rs2 value
in_imm  in  XLEN  sign-extended immediate
in_funct3  in  3  RV32I funct3
in_funct7b5  in  1  instr[30]
in_kind  in  3  0=OP, 1=OP-IMM, 2=BRANCH, 3=LUI, 4=AUIPC; 5-7 illegal
in_rd  in  RD_W  destination index
alu_r1  out  XLEN  ALU operand 1
alu_r2  out  XLEN  ALU operand 2
alu_sub  out  4  ALU op code
alu_enable  out  1  ALU enable
alu_sum  in  XLEN  ALU result
alu_overflow  in  1  ALU overflow (ignored except for debug)
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
out_result  out  XLEN  rd write data (0 for branches)
out_rd  out  RD_W  destination index
out_wen  out  1  rd write enable (0 for branch, rd==0, or illegal)
out_br_taken  out  1  branch taken
out_br_target  out  XLEN  pc+imm when taken, else 0

Behaviour:
- ALU codes: ADD 0000, SUB 0001, AND 0011, OR 0100, XOR 0101, SLT-signed 0110, SLTU 0111, SLL 1000, SRL 1001, SRA 1010, EQ 1011.
- Code 0110 returns 1 iff r1<r2 signed. 0111 returns 1 iff r1<r2 unsigned. 1011 returns 1 iff equal.
- FSM states: IDLE, EXEC, BR_TGT, DONE. All registers are updated only on a rising clk.
- Reset: state=IDLE. in_ready=1. out_valid=0. out_result, out_rd, out_wen, out_br_taken, out_br_target = 0. alu_enable=0. alu_r1/alu_r2/alu_sub=0. Latched micro-op = 0.
- IDLE: in_ready=1. On in_valid, latch all in_* fields and go to EXEC.
- alu_enable=1 only in EXEC and BR_TGT. In all other states, alu_r1/alu_r2/alu_sub are driven to 0.
- EXEC operand selection:
  - OP: r1=rs1, r2=rs2.
  - OP-IMM: r1=rs1, r2=imm.
  - LUI: r1=0, r2=imm, ADD.
  - AUIPC: r1=pc, r2=imm, ADD.
  - BRANCH: r1=rs1, r2=rs2.
- EXEC op selection by funct3:
  - 000: ADD, or SUB when kind=OP and funct7b5=1. OP-IMM with funct3=000 is always ADD.
  - 001: SLL.
  - 010: 0110.
  - 011: 0111.
  - 100: XOR.
  - 101: SRL, or SRA when funct7b5=1.
  - 110: OR.
  - 111: AND.
  - Shift amount is r2[4:0].
- Non-branch EXEC: register alu_sum into out_result, set out_wen=(rd!=0), go to DONE. Latency from input handshake to out_valid is 2 cycles.
- Branch EXEC op selection:
  - BEQ/BNE use EQ.
  - BLT/BGE use 0110.
  - BLTU/BGEU use 0111.
  - taken = result[0], XOR 1 for BNE, BGE, BGEU.
  - Register taken and go to BR_TGT.
- Branch funct3 010/011 is illegal: taken=0, skip BR_TGT, go to DONE.
- BR_TGT: r1=pc, r2=imm, ADD. out_br_target = taken ? alu_sum : 0. out_wen=0, out_result=0. Go to DONE. Branch latency is 3 cycles.
- Illegal kind (5-7): skip the ALU. alu_enable stays 0 in EXEC. Result is 0, wen=0, taken=0. Still go to DONE.
- DONE: out_valid=1 and in_ready=0. Outputs hold stable while out_ready=0.
  - On out_ready=1: drop out_valid, go to IDLE. in_ready=1 the following cycle; there is no same-cycle refill.
- in_valid is ignored outside IDLE.
- rst asserted in any state (including EXEC, BR_TGT, or DONE with out_valid high) returns to reset values next edge. The in-flight op is discarded and no output handshake occurs.
- Wrap-around: pc+imm, LUI, and all adds are modulo 2^32. Overflow is not flagged.

Test Plan:
- Reset: hold rst 2 cycles mid-DONE. Required: out_valid=0, in_ready=1, alu_enable=0, all outputs 0.
- OP SUB: rs1=5, rs2=7, rd=3, out_ready=1. Required: EXEC shows alu_sub=0001; 2 cycles later out_result=0xFFFFFFFE, out_wen=1, out_rd=3.
- OP-IMM SRAI: rs1=0x80000000, imm=0x404, funct3=101, funct7b5=1. Required: alu_sub=1010, out_result=0xF8000000.
- BGE: rs1=0xFFFFFFFF, rs2=1, pc=0x80000010, imm=-8. Required: not taken, out_br_target=0. Same op with rs1=2: taken, target=0x80000008, out_valid at cycle 3.
- Backpressure: hold out_ready=0 for 5 cycles after LUI with imm=0x12345000. Required: out_valid and out_result=0x12345000 stable, in_ready=0, a second in_valid ignored. Release: one handshake, then IDLE.
- rd=0 SLTIU: rs1=0, imm=1. Required: out_result=1, out_wen=0. Illegal kind=6: out_wen=0, alu_enable never 1.
